// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - RV32I decode/issue stage with one-entry output register and CDB operand snooping
module issue_stage #(
    parameter int XLEN      = 32,
    parameter int ROB_POS_W = 4,
    parameter int CDB_N     = 2,
    parameter int OPENUM_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_inst,
    input  logic [OPENUM_W-1:0]       in_openum,
    input  logic [XLEN-1:0]           in_pc,
    input  logic                      in_pred_jump,
    input  logic                      in_to_rs,
    input  logic                      in_to_lsb,
    output logic [4:0]                rs1_idx,
    output logic [4:0]                rs2_idx,
    input  logic [XLEN-1:0]           rf_rs1_val,
    input  logic [XLEN-1:0]           rf_rs2_val,
    input  logic [ROB_POS_W-1:0]      rf_rs1_tag,
    input  logic [ROB_POS_W-1:0]      rf_rs2_tag,
    output logic [ROB_POS_W-1:0]      rob_q1_tag,
    output logic [ROB_POS_W-1:0]      rob_q2_tag,
    input  logic                      rob_q1_ready,
    input  logic                      rob_q2_ready,
    input  logic [XLEN-1:0]           rob_q1_val,
    input  logic [XLEN-1:0]           rob_q2_val,
    input  logic [ROB_POS_W-1:0]      rob_next_tag,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_POS_W-1:0] cdb_tag,
    input  logic [CDB_N*XLEN-1:0]     cdb_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPENUM_W-1:0]       out_openum,
    output logic [4:0]                out_rd,
    output logic [XLEN-1:0]           out_rs1_val,
    output logic [XLEN-1:0]           out_rs2_val,
    output logic [ROB_POS_W-1:0]      out_rs1_tag,
    output logic [ROB_POS_W-1:0]      out_rs2_tag,
    output logic [XLEN-1:0]           out_imm,
    output logic [XLEN-1:0]           out_pc,
    output logic                      out_pred_jump,
    output logic                      out_ready_inst,
    output logic [ROB_POS_W-1:0]      out_rob_tag,
    output logic                      out_to_rs,
    output logic                      out_to_lsb
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic                 full;
    logic [XLEN-1:0]      r_rs1_val, r_rs2_val;
    logic [ROB_POS_W-1:0] r_rs1_tag, r_rs2_tag;
    logic                 accept, issue;
    logic                 unused_funct3;

    // Returns {hit, value}; iterating downward makes the lowest matching port win.
    function automatic logic [XLEN:0] cdb_find(
        input logic [ROB_POS_W-1:0]       tag,
        input logic [CDB_N-1:0]           v,
        input logic [CDB_N*ROB_POS_W-1:0] t,
        input logic [CDB_N*XLEN-1:0]      d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int i = CDB_N - 1; i >= 0; i--) begin
            if (v[i] && tag != '0 && t[i*ROB_POS_W +: ROB_POS_W] == tag)
                r = {1'b1, d[i*XLEN +: XLEN]};
        end
        return r;
    endfunction

    logic [XLEN:0] acc1, acc2, snp1, snp2;
    assign acc1 = cdb_find(rf_rs1_tag, cdb_valid, cdb_tag, cdb_val);
    assign acc2 = cdb_find(rf_rs2_tag, cdb_valid, cdb_tag, cdb_val);
    assign snp1 = cdb_find(r_rs1_tag, cdb_valid, cdb_tag, cdb_val);
    assign snp2 = cdb_find(r_rs2_tag, cdb_valid, cdb_tag, cdb_val);

    assign rs1_idx       = in_inst[19:15];
    assign rs2_idx       = in_inst[24:20];
    assign rob_q1_tag    = rf_rs1_tag;
    assign rob_q2_tag    = rf_rs2_tag;
    assign unused_funct3 = ^in_inst[14:12];

    assign in_ready = rdy & ~clr & ~rst & (~full | out_ready);
    assign accept   = in_valid & in_ready;
    assign issue    = full & out_ready & rdy;

    logic [XLEN-1:0]      res1_val, res2_val, d_imm, d_rs1_val, d_rs2_val;
    logic [ROB_POS_W-1:0] res1_tag, res2_tag, d_rs1_tag, d_rs2_tag;
    logic [4:0]           d_rd;
    logic                 d_ready_inst, use1, use2;

    always_comb begin
        res1_val = '0;
        res1_tag = '0;
        res2_val = '0;
        res2_tag = '0;
        if (rf_rs1_tag == '0)  res1_val = rf_rs1_val;
        else if (rob_q1_ready) res1_val = rob_q1_val;
        else if (acc1[XLEN])   res1_val = acc1[XLEN-1:0];
        else                   res1_tag = rf_rs1_tag;
        if (rf_rs2_tag == '0)  res2_val = rf_rs2_val;
        else if (rob_q2_ready) res2_val = rob_q2_val;
        else if (acc2[XLEN])   res2_val = acc2[XLEN-1:0];
        else                   res2_tag = rf_rs2_tag;
    end

    always_comb begin
        d_rd         = in_inst[11:7];
        d_imm        = '0;
        d_ready_inst = 1'b0;
        use1         = 1'b1;
        use2         = 1'b1;
        case (in_inst[6:0])
            OP_R: ;
            OP_IALU, OP_LOAD, OP_JALR: begin
                use2  = 1'b0;
                d_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                d_rd         = '0;
                d_ready_inst = 1'b1;
                d_imm        = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                d_rd  = '0;
                d_imm = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_JAL: begin
                use1  = 1'b0;
                use2  = 1'b0;
                d_imm = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                use1  = 1'b0;
                use2  = 1'b0;
                d_imm = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
            end
            default: ;
        endcase
        d_rs1_val = use1 ? res1_val : '0;
        d_rs1_tag = use1 ? res1_tag : '0;
        d_rs2_val = use2 ? res2_val : '0;
        d_rs2_tag = use2 ? res2_tag : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full           <= 1'b0;
            out_openum     <= '0;
            out_rd         <= '0;
            r_rs1_val      <= '0;
            r_rs2_val      <= '0;
            r_rs1_tag      <= '0;
            r_rs2_tag      <= '0;
            out_imm        <= '0;
            out_pc         <= '0;
            out_pred_jump  <= 1'b0;
            out_ready_inst <= 1'b0;
            out_rob_tag    <= '0;
            out_to_rs      <= 1'b0;
            out_to_lsb     <= 1'b0;
        end else if (rdy) begin
            if (clr) begin
                full <= 1'b0;
            end else if (accept) begin
                full           <= 1'b1;
                out_openum     <= in_openum;
                out_rd         <= d_rd;
                r_rs1_val      <= d_rs1_val;
                r_rs2_val      <= d_rs2_val;
                r_rs1_tag      <= d_rs1_tag;
                r_rs2_tag      <= d_rs2_tag;
                out_imm        <= d_imm;
                out_pc         <= in_pc;
                out_pred_jump  <= in_pred_jump;
                out_ready_inst <= d_ready_inst;
                out_rob_tag    <= rob_next_tag;
                out_to_rs      <= in_to_rs;
                out_to_lsb     <= in_to_lsb;
            end else begin
                if (issue)
                    full <= 1'b0;
                if (full && snp1[XLEN]) begin
                    r_rs1_val <= snp1[XLEN-1:0];
                    r_rs1_tag <= '0;
                end
                if (full && snp2[XLEN]) begin
                    r_rs2_val <= snp2[XLEN-1:0];
                    r_rs2_tag <= '0;
                end
            end
        end
    end

    // Same-cycle broadcast overlays the held operands so an issuing bundle never misses it.
    assign out_valid   = full;
    assign out_rs1_val = (rdy && snp1[XLEN]) ? snp1[XLEN-1:0] : r_rs1_val;
    assign out_rs1_tag = (rdy && snp1[XLEN]) ? '0 : r_rs1_tag;
    assign out_rs2_val = (rdy && snp2[XLEN]) ? snp2[XLEN-1:0] : r_rs2_val;
    assign out_rs2_tag = (rdy && snp2[XLEN]) ? '0 : r_rs2_tag;
endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - directed bench for issue_stage with a behavioural reference model
module tb_issue_stage;
    localparam int XLEN = 32;
    localparam int RW   = 4;
    localparam int CN   = 2;
    localparam int OW   = 6;

    logic clk, rst, rdy, clr, in_valid, in_ready;
    logic [31:0] in_inst;
    logic [OW-1:0] in_openum;
    logic [31:0] in_pc;
    logic in_pred_jump, in_to_rs, in_to_lsb;
    logic [4:0] rs1_idx, rs2_idx;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic [RW-1:0] rf_rs1_tag, rf_rs2_tag, rob_q1_tag, rob_q2_tag;
    logic rob_q1_ready, rob_q2_ready;
    logic [31:0] rob_q1_val, rob_q2_val;
    logic [RW-1:0] rob_next_tag;
    logic [CN-1:0] cdb_valid;
    logic [CN*RW-1:0] cdb_tag;
    logic [CN*XLEN-1:0] cdb_val;
    logic out_valid, out_ready;
    logic [OW-1:0] out_openum;
    logic [4:0] out_rd;
    logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
    logic [RW-1:0] out_rs1_tag, out_rs2_tag, out_rob_tag;
    logic out_pred_jump, out_ready_inst, out_to_rs, out_to_lsb;

    issue_stage #(.XLEN(XLEN), .ROB_POS_W(RW), .CDB_N(CN), .OPENUM_W(OW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_openum(in_openum),
        .in_pc(in_pc), .in_pred_jump(in_pred_jump), .in_to_rs(in_to_rs), .in_to_lsb(in_to_lsb),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val), .rf_rs1_tag(rf_rs1_tag), .rf_rs2_tag(rf_rs2_tag),
        .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag), .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val), .rob_next_tag(rob_next_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_openum(out_openum), .out_rd(out_rd),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rs1_tag(out_rs1_tag), .out_rs2_tag(out_rs2_tag),
        .out_imm(out_imm), .out_pc(out_pc), .out_pred_jump(out_pred_jump), .out_ready_inst(out_ready_inst),
        .out_rob_tag(out_rob_tag), .out_to_rs(out_to_rs), .out_to_lsb(out_to_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] openum;
        logic [4:0]    rd;
        logic [31:0]   v1, v2;
        logic [RW-1:0] t1, t2;
        logic [31:0]   imm, pc;
        logic          pj, ri;
        logic [RW-1:0] rob;
        logic          to_rs, to_lsb;
    } bundle_t;

    bundle_t m;
    logic    m_valid;
    int      n_cmp = 0;
    int      n_bad = 0;
    bit      checking = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        return v[bits-1] ? v - (32'd1 << bits) : v;
    endfunction

    function automatic void cdb_lookup(input logic [RW-1:0] tag, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (tag != '0)
            for (int p = 0; p < CN; p++)
                if (!hit && cdb_valid[p] && cdb_tag[p*RW +: RW] == tag) begin
                    hit = 1'b1;
                    val = cdb_val[p*XLEN +: XLEN];
                end
    endfunction

    function automatic void resolve(input logic [RW-1:0] ft, input logic [31:0] fv, input logic rr,
                                    input logic [31:0] rv, output logic [31:0] v, output logic [RW-1:0] t);
        logic h;
        logic [31:0] cv;
        v = '0;
        t = '0;
        cdb_lookup(ft, h, cv);
        if (ft == '0) v = fv;
        else if (rr)  v = rv;
        else if (h)   v = cv;
        else          t = ft;
    endfunction

    function automatic bundle_t decode_model();
        bundle_t b;
        logic [31:0] x;
        logic need1, need2;
        x = in_inst;
        b = '0;
        need1 = 1'b1;
        need2 = 1'b1;
        b.openum = in_openum;
        b.pc = in_pc;
        b.pj = in_pred_jump;
        b.to_rs = in_to_rs;
        b.to_lsb = in_to_lsb;
        b.rob = rob_next_tag;
        b.rd = x[11:7];
        case (x[6:0])
            7'h13, 7'h03, 7'h67: begin need2 = 0; b.imm = sx({20'b0, x[31:20]}, 12); end
            7'h23: begin b.rd = 0; b.ri = 1; b.imm = sx({20'b0, x[31:25], x[11:7]}, 12); end
            7'h63: begin b.rd = 0; b.imm = sx({19'b0, x[31], x[7], x[30:25], x[11:8], 1'b0}, 13); end
            7'h6F: begin need1 = 0; need2 = 0; b.imm = sx({11'b0, x[31], x[19:12], x[20], x[30:21], 1'b0}, 21); end
            7'h37, 7'h17: begin need1 = 0; need2 = 0; b.imm = {12'b0, x[31:12]} * 32'd4096; end
            default: ;
        endcase
        if (need1) resolve(rf_rs1_tag, rf_rs1_val, rob_q1_ready, rob_q1_val, b.v1, b.t1);
        if (need2) resolve(rf_rs2_tag, rf_rs2_val, rob_q2_ready, rob_q2_val, b.v2, b.t2);
        return b;
    endfunction

    logic u_hit;
    logic [31:0] u_val;
    always @(posedge clk) begin
        if (rst) begin
            m = '0;
            m_valid = 1'b0;
        end else if (rdy) begin
            if (clr) begin
                m_valid = 1'b0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                m = decode_model();
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end else if (m_valid) begin
                cdb_lookup(m.t1, u_hit, u_val);
                if (u_hit) begin m.v1 = u_val; m.t1 = '0; end
                cdb_lookup(m.t2, u_hit, u_val);
                if (u_hit) begin m.v2 = u_val; m.t2 = '0; end
            end
        end
    end

    logic c_hit;
    logic [31:0] c_val, e1v, e2v;
    logic [RW-1:0] e1t, e2t;
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", in_ready, rdy & ~clr & ~rst & (~m_valid | out_ready));
            chk("out_valid", out_valid, m_valid);
            chk("rs1_idx", rs1_idx, in_inst[19:15]);
            chk("rob_q2_tag", rob_q2_tag, rf_rs2_tag);
            if (m_valid) begin
                e1v = m.v1; e1t = m.t1; e2v = m.v2; e2t = m.t2;
                if (rdy) begin
                    cdb_lookup(m.t1, c_hit, c_val);
                    if (c_hit) begin e1v = c_val; e1t = '0; end
                    cdb_lookup(m.t2, c_hit, c_val);
                    if (c_hit) begin e2v = c_val; e2t = '0; end
                end
                chk("rs1_val", out_rs1_val, e1v);
                chk("rs1_tag", out_rs1_tag, e1t);
                chk("rs2_val", out_rs2_val, e2v);
                chk("rs2_tag", out_rs2_tag, e2t);
                chk("openum", out_openum, m.openum);
                chk("rd", out_rd, m.rd);
                chk("imm", out_imm, m.imm);
                chk("pc", out_pc, m.pc);
                chk("flags", {out_pred_jump, out_ready_inst, out_to_rs, out_to_lsb}, {m.pj, m.ri, m.to_rs, m.to_lsb});
                chk("rob_tag", out_rob_tag, m.rob);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [RW-1:0] rob);
        in_valid = 1'b1;
        in_inst = inst;
        in_pc = pc;
        rob_next_tag = rob;
        in_openum = OW'(pc[7:2]);
        in_pred_jump = pc[2];
        in_to_rs = ~pc[3];
        in_to_lsb = pc[3];
    endtask

    task automatic set_cdb(input int p, input logic [RW-1:0] t, input logic [31:0] v);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*RW +: RW] = t;
        cdb_val[p*XLEN +: XLEN] = v;
    endtask

    task automatic quiet();
        in_valid = 0; cdb_valid = '0;
        rf_rs1_tag = 0; rf_rs2_tag = 0; rob_q1_ready = 0; rob_q2_ready = 0;
    endtask

    initial begin
        rst = 1; rdy = 1; clr = 0; in_valid = 0; in_inst = 0; in_openum = 0; in_pc = 0;
        in_pred_jump = 0; in_to_rs = 0; in_to_lsb = 0; rf_rs1_val = 0; rf_rs2_val = 0;
        rf_rs1_tag = 0; rf_rs2_tag = 0; rob_q1_ready = 0; rob_q2_ready = 0; rob_q1_val = 0;
        rob_q2_val = 0; rob_next_tag = 0; cdb_valid = 0; cdb_tag = 0; cdb_val = 0; out_ready = 0;
        tick(); tick();
        checking = 1;
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset imm", out_imm, 0);
        tick();
        rst = 0;

        // regfile hit
        drive(32'h00708293, 32'h100, 1);
        rf_rs1_val = 32'h10; rf_rs2_tag = 3; rf_rs2_val = 32'h99; out_ready = 1;
        tick(); quiet();
        @(negedge clk);
        chk("rf out_valid", out_valid, 1);
        chk("rf rs1_val", out_rs1_val, 32'h10);
        chk("rf rs2_tag", out_rs2_tag, 0);
        chk("rf imm", out_imm, 7);
        chk("rf rd", out_rd, 5);
        tick();

        // CDB port 1 resolves at accept; ROB-ready and unresolved cases follow
        drive(32'h004181B3, 32'h104, 2);
        rf_rs1_tag = 3; rf_rs2_val = 32'h22; set_cdb(1, 3, 32'hAB);
        tick(); quiet();
        drive(32'h004181B3, 32'h108, 3);
        rf_rs1_tag = 2; rob_q1_ready = 1; rob_q1_val = 32'h77; rf_rs2_tag = 5;
        @(negedge clk);
        chk("cdb acc rs1_val", out_rs1_val, 32'hAB);
        chk("cdb acc rs1_tag", out_rs1_tag, 0);
        tick(); quiet();
        @(negedge clk);
        chk("rob rs1_val", out_rs1_val, 32'h77);
        chk("pend rs2_tag", out_rs2_tag, 5);
        tick();

        // snoop while stalled
        out_ready = 0;
        drive(32'h004181B3, 32'h10C, 7);
        rf_rs1_val = 32'h31; rf_rs2_tag = 6;
        tick(); quiet();
        drive(32'h00708293, 32'h110, 8);
        tick(); tick();
        set_cdb(0, 6, 32'h55);
        tick(); cdb_valid = 0; in_valid = 0;
        @(negedge clk);
        chk("snoop rs2_tag", out_rs2_tag, 0);
        chk("snoop rs2_val", out_rs2_val, 32'h55);
        chk("snoop rob_tag", out_rob_tag, 7);
        out_ready = 1;
        tick();
        @(negedge clk);
        chk("snoop issued", out_valid, 0);

        // bypass on issue
        out_ready = 0;
        drive(32'h004181B3, 32'h114, 9);
        rf_rs1_tag = 4;
        tick(); quiet();
        out_ready = 1; set_cdb(0, 4, 32'd9);
        @(negedge clk);
        chk("bypass rs1_val", out_rs1_val, 9);
        chk("bypass rs1_tag", out_rs1_tag, 0);
        tick(); quiet();

        // duplicate tag on both ports: port 0 wins
        drive(32'h004181B3, 32'h118, 10);
        rf_rs1_tag = 5; set_cdb(0, 5, 32'h111); set_cdb(1, 5, 32'h222);
        tick(); quiet();
        @(negedge clk);
        chk("dup port0", out_rs1_val, 32'h111);
        tick();

        // back-to-back immediates
        drive(32'hFE20AE23, 32'h200, 11);
        tick(); drive(32'hFE208CE3, 32'h204, 12);
        @(negedge clk);
        chk("sw imm", out_imm, 32'hFFFFFFFC);
        chk("sw rd", out_rd, 0);
        chk("sw ready_inst", out_ready_inst, 1);
        tick(); drive(32'h001000EF, 32'h208, 13);
        @(negedge clk);
        chk("beq imm", out_imm, 32'hFFFFFFF8);
        tick(); drive(32'h123453B7, 32'h20C, 14);
        @(negedge clk);
        chk("jal imm", out_imm, 32'h800);
        tick(); quiet();
        @(negedge clk);
        chk("lui imm", out_imm, 32'h12345000);
        tick();

        // rdy=0 freezes state and snoop
        out_ready = 0;
        drive(32'h004181B3, 32'h300, 5);
        rf_rs2_tag = 2;
        tick(); quiet();
        rdy = 0; out_ready = 1; set_cdb(0, 2, 32'hDEAD); drive(32'h00708293, 32'h304, 6);
        tick(); tick();
        @(negedge clk);
        chk("frozen rs2_tag", out_rs2_tag, 2);
        rdy = 1; quiet(); out_ready = 0;
        tick();

        // flush with a full entry and a pending instruction
        drive(32'h00708293, 32'h400, 3);
        clr = 1;
        @(negedge clk);
        chk("clr in_ready", in_ready, 0);
        tick(); clr = 0; quiet();
        @(negedge clk);
        chk("clr out_valid", out_valid, 0);
        tick();

        // reset during a stall
        drive(32'h00708293, 32'h500, 4);
        tick(); quiet();
        tick();
        rst = 1;
        tick();
        @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst pc", out_pc, 0);
        chk("rst rob_tag", out_rob_tag, 0);
        chk("rst rd", out_rd, 0);
        tick();
        rst = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_stage.md
# issue_stage

Registered, parametrised decode/issue stage between instruction fetch and the back end (ROB, reservation station, load/store buffer). It decodes one RV32I instruction per cycle and resolves both source operands from the regfile, the ROB, or any of `CDB_N` common-data-bus ports. It holds the issued bundle in a one-entry output register behind a valid/ready handshake. While held, it keeps snooping the CDB so that stalled operands become ready in place.

## Interface
- `XLEN`, 32: data/address width.
- `ROB_POS_W`, 4: ROB tag width; tag 0 means "no dependency / value valid".
- `CDB_N`, 2: number of broadcast ports; port 0 is ALU, port 1 is LSB load, further ports are extra units.
- `OPENUM_W`, 6: width of the pre-decoded opcode enum.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; 0 freezes all state.
- `clr` in 1: misprediction flush, synchronous.
- `in_valid` in 1, `in_ready` out 1: fetch handshake.
- `in_inst` in 32, `in_openum` in OPENUM_W, `in_pc` in XLEN, `in_pred_jump` in 1, `in_to_rs` in 1, `in_to_lsb` in 1: fetched instruction and its attributes.
- `rs1_idx`, `rs2_idx` out 5: combinational `in_inst[19:15]` and `in_inst[24:20]`, to the regfile.
- `rf_rs1_val`, `rf_rs2_val` in XLEN; `rf_rs1_tag`, `rf_rs2_tag` in ROB_POS_W: regfile lookup result.
- `rob_q1_tag`, `rob_q2_tag` out ROB_POS_W: equal to `rf_rs1_tag` and `rf_rs2_tag`.
- `rob_q1_ready`, `rob_q2_ready` in 1; `rob_q1_val`, `rob_q2_val` in XLEN: ROB lookup result.
- `rob_next_tag` in ROB_POS_W: tag to be allocated to this instruction.
- `cdb_valid` in CDB_N; `cdb_tag` in CDB_N*ROB_POS_W; `cdb_val` in CDB_N*XLEN: broadcast buses.
- `out_valid` out 1, `out_ready` in 1: issue handshake. `out_ready` is ROB not full and the target unit not full.
- Issue bundle:
  - `out_openum` out OPENUM_W
  - `out_rd` out 5
  - `out_rs1_val`, `out_rs2_val` out XLEN
  - `out_rs1_tag`, `out_rs2_tag` out ROB_POS_W
  - `out_imm` out XLEN
  - `out_pc` out XLEN
  - `out_pred_jump` out 1
  - `out_ready_inst` out 1
  - `out_rob_tag` out ROB_POS_W
  - `out_to_rs` out 1
  - `out_to_lsb` out 1

## Operation

**Entry state.** One entry, with states EMPTY and FULL (`out_valid`).

**Input handshake.**
- `in_ready = rdy & ~clr & ~rst & (~out_valid | out_ready)`.
- Accept is `in_valid & in_ready`. On accept, the entry loads and the state becomes FULL.
- Issue is `out_valid & out_ready & rdy`. Issue without accept makes the state EMPTY. Issue and accept in the same cycle keep it FULL with the new bundle.

**Operand resolution at accept**, per source, first match wins:
1. rf tag == 0: rf value, tag 0.
2. ROB ready: ROB value, tag 0.
3. Lowest-index CDB port with `valid` and a tag match: CDB value, tag 0.
4. Otherwise: value 0, tag = rf tag.

**Snoop while FULL.** For each held tag != 0, if a CDB port matches, load its value and clear the tag. Lowest index wins.

**Output bypass.** `out_rsX_val` and `out_rsX_tag` combinationally overlay a same-cycle CDB match, so a broadcast coinciding with issue is never lost.

**Decode by `in_inst[6:0]`.**
- R (0110011): both sources kept, imm 0.
- I-ALU (0010011), LOAD (0000011), JALR (1100111): rs2 forced to value 0, tag 0; imm = sext(inst[31:20]).
- STORE (0100011): rd 0; `ready_inst` = 1; imm = sext({inst[31:25], inst[11:7]}).
- BRANCH (1100011): rd 0; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- JAL (1101111): rs1 and rs2 forced to 0; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- LUI (0110111), AUIPC (0010111): rs1 and rs2 forced to 0; imm = {inst[31:12], 12'b0}.
- Any other opcode: fields are passed through, both sources are resolved, imm is 0.

**Pass-through fields.** `out_rob_tag` ← `rob_next_tag`; `pc`, `openum`, `pred_jump`, `to_rs`, `to_lsb` are registered unchanged.

## Timing
- **Reset** (`rst`=1 at an edge): every output register is 0. `out_valid`=0 and `in_ready`=0 during reset.
- **Latency:** 1 cycle from accept to `out_valid`.
- **Throughput:** 1 instruction per cycle while `out_ready`=1.
- **Stall:** while `out_valid` & ~`out_ready`, all bundle fields stay stable except tag→value resolution from the snoop. Holding a bundle stable is independent of `in_valid`.
- **clr:** on the next edge `out_valid`=0. No accept and no issue is counted in a clr cycle. clr together with rst behaves like rst.
- **rdy=0:** no register changes and no snoop. Outputs hold; the consumer is gated by rdy as well.
- **Same tag on two CDB ports** (an illegal condition): port 0 wins.
- **Store and branch sources:** these have no rd, but their source tags are still resolved.

## Test plan
- **Regfile hit.** ADDI x5, x1, 7 with rf_rs1_tag=0 and rf_rs1_val=0x10, out_ready=1 → next cycle out_valid=1, rs1_val=0x10, rs1_tag=0, rs2_tag=0, imm=7, rd=5.
- **CDB at accept.** ADD with rf_rs1_tag=3, rob_q1_ready=0, and CDB port 1 broadcasting tag 3, value 0xAB → rs1_val=0xAB, rs1_tag=0.
- **Snoop while stalled.** out_ready=0 with rs2_tag=6 held; 2 cycles later CDB port 0 sends tag 6, value 0x55 → next cycle rs2_tag=0, rs2_val=0x55, and other fields are unchanged. Raising out_ready then issues it.
- **Bypass on issue.** Issue cycle with rs1_tag=4 while CDB port 0 sends tag 4, value 9 → `out_rs1_val`=9 and tag 0 in that same cycle.
- **Immediates.** SW with imm −4 → imm=0xFFFFFFFC, rd=0, ready_inst=1. BEQ with offset −8 → imm=0xFFFFFFF8. JAL with offset 2048 → imm=0x800. LUI 0x12345 → imm=0x12345000.
- **Flush and reset.** clr asserted with the entry FULL and in_valid=1 → next cycle out_valid=0 and nothing is accepted. rst mid-stall → all outputs 0.
